// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants, types and helpers for the 7-segment scan driver
package seg7_pkg;

  // Active-high segment patterns {g,f,e,d,c,b,a} for hex values 0..F
  localparam logic [6:0] SEG_TABLE [0:15] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

  // All segments off
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Phase within one digit slot: the first cycle is dark, the rest drive the digit
  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_LIT   = 1'b1
  } scan_phase_e;

  // Counter width for a modulus of n, never less than one bit
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// rtl/seg7_hex_decoder.sv - combinational 4-bit hex value to 7-segment glyph decoder
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] i_value,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_TABLE[i_value];

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed 7-segment scan driver; optional SEG7_LEADING_ZERO_BLANK_EN
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 4
)
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data_in,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  slot_done
);

  localparam int IW = idx_width(DIGITS);
  localparam int DW = idx_width(SCAN_DIV);

  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

  logic [4*DIGITS-1:0] r_snap;
  logic [IW-1:0]       r_idx;
  logic [DW-1:0]       r_div;
  logic [DIGITS-1:0]   r_an;
  logic [6:0]          r_seg;
  logic                r_slot_done;

  scan_phase_e         w_phase;
  logic [3:0]          w_digit;
  logic [6:0]          w_dec_seg;
  logic [6:0]          w_seg_lit;
  logic [DIGITS-1:0]   w_an_lit;
  logic                w_suppress;
  logic                w_last_cycle;

  // Snapshot register: a load replaces the digits immediately, even mid-slot
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_snap <= '0;
    end else if (load) begin
      r_snap <= data_in;
    end
  end

  // Prescaler and digit index: advance to the next digit when a slot ends
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_div <= '0;
      r_idx <= '0;
    end else if (r_div == DIV_LAST) begin
      r_div <= '0;
      r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
    end else begin
      r_div <= r_div + DW'(1);
    end
  end

  // Slot phase: first cycle of every slot is dark to avoid ghosting
  always_comb begin
    w_phase = (r_div == '0) ? PH_BLANK : PH_LIT;
  end

  // Select the snapshot nibble for the digit currently being scanned
  always_comb begin
    w_digit = 4'h0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_idx == IW'(i)) begin
        w_digit = r_snap[4*i +: 4];
      end
    end
  end

  seg7_hex_decoder u_hex_decoder (
    .i_value (w_digit),
    .o_seg   (w_dec_seg)
  );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic w_upper_zero;

  // Dark a non-zero-index digit when it and every digit above it are zero
  always_comb begin
    w_upper_zero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if ((IW'(i) >= r_idx) && (r_snap[4*i +: 4] != 4'h0)) begin
        w_upper_zero = 1'b0;
      end
    end
    w_suppress = (r_idx != '0) && w_upper_zero;
  end
`else
  assign w_suppress = 1'b0;
`endif

  assign w_seg_lit    = w_suppress ? SEG_BLANK : w_dec_seg;
  assign w_an_lit     = ~(DIGITS'(1) << r_idx);
  assign w_last_cycle = (r_div == DIV_LAST) && (r_idx == IDX_LAST);

  // Output registers: one cycle behind the index/prescaler/snapshot state
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_an        <= '1;
      r_seg       <= SEG_BLANK;
      r_slot_done <= 1'b0;
    end else begin
      r_slot_done <= w_last_cycle;
      if (w_phase == PH_BLANK) begin
        r_an  <= '1;
        r_seg <= SEG_BLANK;
      end else begin
        r_an  <= w_an_lit;
        r_seg <= w_seg_lit;
      end
    end
  end

  assign an        = r_an;
  assign seg       = r_seg;
  assign slot_done = r_slot_done;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - self-checking bench for seg7_scan_driver (DIGITS=4, SCAN_DIV=4)
module tb_seg7_scan_driver;

  localparam int ND = 4;
  localparam int NS = 4;

  logic          clk;
  logic          reset;
  logic          load;
  logic [15:0]   data_in;
  logic [3:0]    an;
  logic [6:0]    seg;
  logic          slot_done;

  int n_checks;
  int n_errors;

  seg7_scan_driver #(.DIGITS(ND), .SCAN_DIV(NS)) dut (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .data_in   (data_in),
    .an        (an),
    .seg       (seg),
    .slot_done (slot_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent glyph table
  logic [6:0] ref_seg [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Reference model: time since reset and a copy of the snapshot
  int          m_t;
  logic [15:0] m_snap;
  logic [3:0]  m_an;
  logic [6:0]  m_seg;
  logic        m_sd;

  task automatic model_edge(input logic r, input logic l, input logic [15:0] d);
    int pos;
    int dig;
    int ph;
    if (!r) begin
      m_an   = 4'hF;
      m_seg  = 7'h00;
      m_sd   = 1'b0;
      m_t    = 0;
      m_snap = 16'h0000;
    end else begin
      pos  = m_t % (ND * NS);
      dig  = pos / NS;
      ph   = pos % NS;
      m_sd = (pos == ND * NS - 1);
      if (ph == 0) begin
        m_an  = 4'hF;
        m_seg = 7'h00;
      end else begin
        m_an      = 4'hF;
        m_an[dig] = 1'b0;
        m_seg     = ref_seg[m_snap[4*dig +: 4]];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (dig > 0 && (m_snap >> (4*dig)) == 16'h0000) m_seg = 7'h00;
`endif
      end
      if (l) m_snap = d;
      m_t++;
    end
  endtask

  task automatic step(input logic r, input logic l, input logic [15:0] d);
    reset   = r;
    load    = l;
    data_in = d;
    @(posedge clk);
    model_edge(r, l, d);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        r;
    logic        l;
    logic [15:0] d;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        sd;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic l, input logic [15:0] d,
                     input logic [3:0] a, input logic [6:0] s, input logic sd);
    vec_t v;
    v.r = r; v.l = l; v.d = d; v.an = a; v.seg = s; v.sd = sd;
    tbl.push_back(v);
  endtask

  task automatic scan_check(input string name, input logic [15:0] d, input logic [6:0] e0,
                            input logic [6:0] e1, input logic [6:0] e2, input logic [6:0] e3);
    logic [6:0] exp_seg [4];
    logic [3:0] exp_an;
    exp_seg[0] = e0; exp_seg[1] = e1; exp_seg[2] = e2; exp_seg[3] = e3;
    step(1'b0, 1'b0, 16'h0000);
    step(1'b1, 1'b1, d);
    for (int p = 1; p < ND * NS; p++) begin
      step(1'b1, 1'b0, 16'h0000);
      if (p % NS != 0) begin
        exp_an = 4'hF;
        exp_an[p / NS] = 1'b0;
        chk({name, "_an"}, 32'(an), 32'(exp_an));
        chk({name, "_seg"}, 32'(seg), 32'(exp_seg[p / NS]));
      end else begin
        chk({name, "_blank"}, 32'({an, seg}), 32'({4'hF, 7'h00}));
      end
    end
  endtask

  initial begin
    int sd_cnt;
    logic r;
    logic l;
    logic [15:0] d;
    n_checks = 0;
    n_errors = 0;
    reset   = 1'b0;
    load    = 1'b0;
    data_in = 16'h0000;

    // Directed table: reset with load held, release, 1234 scan, wrap, mid-slot load
    add(0, 1, 16'hFFFF, 4'hF, 7'h00, 0);
    add(0, 1, 16'hFFFF, 4'hF, 7'h00, 0);
    add(1, 0, 16'h0000, 4'hF, 7'h00, 0);
    add(1, 1, 16'h1234, 4'hE, 7'h3F, 0);
    add(1, 0, 16'h0000, 4'hE, 7'h66, 0);
    add(1, 0, 16'h0000, 4'hE, 7'h66, 0);
    add(1, 0, 16'h0000, 4'hF, 7'h00, 0);
    for (int k = 0; k < 3; k++) add(1, 0, 16'h0000, 4'hD, 7'h4F, 0);
    add(1, 0, 16'h0000, 4'hF, 7'h00, 0);
    for (int k = 0; k < 3; k++) add(1, 0, 16'h0000, 4'hB, 7'h5B, 0);
    add(1, 0, 16'h0000, 4'hF, 7'h00, 0);
    add(1, 0, 16'h0000, 4'h7, 7'h06, 0);
    add(1, 0, 16'h0000, 4'h7, 7'h06, 0);
    add(1, 0, 16'h0000, 4'h7, 7'h06, 1);
    add(1, 0, 16'h0000, 4'hF, 7'h00, 0);
    add(1, 0, 16'h0000, 4'hE, 7'h66, 0);
    add(1, 1, 16'h000A, 4'hE, 7'h66, 0);
    add(1, 0, 16'h0000, 4'hE, 7'h77, 0);
    add(1, 0, 16'h0000, 4'hF, 7'h00, 0);
    add(1, 0, 16'h0000, 4'hD, 7'h3F, 0);

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].l, tbl[i].d);
      chk($sformatf("tbl%0d_an", i), 32'(an), 32'(tbl[i].an));
      chk($sformatf("tbl%0d_seg", i), 32'(seg), 32'(tbl[i].seg));
      chk($sformatf("tbl%0d_sd", i), 32'(slot_done), 32'(tbl[i].sd));
    end

    // Full hex range on the upper glyphs
    scan_check("hex", 16'hFEDC, 7'h39, 7'h5E, 7'h79, 7'h71);

    // Leading zeros
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    scan_check("lz", 16'h0040, 7'h3F, 7'h66, 7'h00, 7'h00);
`else
    scan_check("lz", 16'h0040, 7'h3F, 7'h66, 7'h3F, 7'h3F);
`endif

    // slot_done pulses once per full 16-cycle frame
    sd_cnt = 0;
    for (int k = 0; k < 2 * ND * NS; k++) begin
      step(1'b1, 1'b0, 16'h0000);
      if (slot_done) sd_cnt++;
    end
    chk("sd_per_frame", 32'(sd_cnt), 32'd2);

    // Reset asserted mid-slot restarts at digit 0 in the blank phase
    step(1'b1, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 16'h0000);
    chk("midrst", 32'({an, seg, slot_done}), 32'({4'hF, 7'h00, 1'b0}));
    step(1'b1, 1'b1, 16'h5678);
    chk("midrst_blank", 32'({an, seg}), 32'({4'hF, 7'h00}));
    step(1'b1, 1'b0, 16'h0000);
    chk("midrst_d0", 32'({an, seg}), 32'({4'hE, 7'h7F}));

    // Randomized traffic against the reference model
    step(1'b0, 1'b0, 16'h0000);
    for (int k = 0; k < 3000; k++) begin
      r = ($urandom_range(0, 63) != 0);
      l = ($urandom_range(0, 7) == 0);
      d = 16'($urandom);
      step(r, l, d);
      chk("rnd_an", 32'(an), 32'(m_an));
      chk("rnd_seg", 32'(seg), 32'(m_seg));
      chk("rnd_sd", 32'(slot_done), 32'(m_sd));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Downstream consumer of the 4-bit counter stage. It snapshots a packed vector of 4-bit digit values (counter q outputs) on a load strobe and time-multiplexes them onto one shared 7-segment bus. Each digit's value is decoded to hex glyphs 0-F. It drives a one-hot, active-low digit-enable bus with a one-cycle blanking gap between digits to suppress ghosting.

Parameters:
DIGITS, 4, number of multiplexed digits; legal range 1..8
SCAN_DIV, 4, clock cycles per digit slot, including the blank cycle; legal minimum 2

Ports:
clk  input  1  single system clock; all logic on rising edge
reset  input  1  synchronous, active-low reset; sampled on rising clk
load  input  1  when 1, data_in is captured into the snapshot register
data_in  input  4*DIGITS  packed digit values; digit i = data_in[4i+3:4i]; digit 0 is least significant
an  output  DIGITS  digit enables, active-low, at most one bit low
seg  output  7  segments {g,f,e,d,c,b,a}, active-high
slot_done  output  1  1-cycle pulse when the last digit (DIGITS-1) slot ends

Behaviour:
- Reset (reset==0 at a rising edge): snap=0, idx=0, div_cnt=0; registered outputs an=all ones, seg=0, slot_done=0. Reset has priority over load.
- Snapshot: on each edge with reset==1 and load==1, snap <= data_in. Otherwise snap holds. A load mid-slot takes effect for the digit currently being scanned.
- Prescaler: div_cnt counts 0..SCAN_DIV-1.
  - When div_cnt==SCAN_DIV-1: div_cnt <= 0, and idx <= (idx==DIGITS-1) ? 0 : idx+1.
  - Otherwise div_cnt increments and idx holds.
  - idx width is max(1, clog2(DIGITS)).
- Scan state machine: each slot is implicitly two phases.
  - BLANK: the div_cnt==0 cycle.
  - LIT: div_cnt in 1..SCAN_DIV-1.
- Outputs are registered, with one cycle of latency from (idx, div_cnt, snap) to (an, seg).
  - BLANK phase: an=all ones, seg=0.
  - LIT phase: an=~(1<<idx), seg=decode(snap digit idx).
- slot_done: registered, 1 for one cycle following the cycle in which div_cnt==SCAN_DIV-1 and idx==DIGITS-1.
- Decode (hex, active-high):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- DIGITS==1: idx is constant 0. The slot still blanks for one cycle every SCAN_DIV cycles, and slot_done pulses every slot.
- Reset asserted mid-slot: the next edge forces the reset values above. Scanning restarts at digit 0 in the BLANK phase.

Optional Feature:
Macro name: SEG7_LEADING_ZERO_BLANK_EN
- Defined: during LIT, digit i>0 drives seg=0 when snap digit i and every higher digit are zero. an still enables the digit, so timing is unchanged. Digit 0 is never suppressed.
- Undefined: all digits always decode normally, so leading zeros show as 3F.

Decomposition:
- Package seg7_pkg holds:
  - the 16-entry segment decode constant table
  - the SEG_BLANK constant (7'h00)
  - an idx-width helper function
- One combinational sub-module, seg7_hex_decoder (4-bit value in, 7-bit seg out). It is instanced once, on the muxed digit.
- The prescaler, index counter, snapshot and output registers stay in seg7_scan_driver.

Test Plan:
All scenarios use DIGITS=4, SCAN_DIV=4.
- Reset: hold reset=0 for 2 cycles with load=1, data_in=16'hFFFF -> an=4'b1111, seg=0, slot_done=0; snap stays 0 (LIT shows seg=3F on each digit after release).
- Basic scan: release reset, pulse load with 16'h1234 -> per slot, 1 blank cycle then 3 cycles of:
  - an=1110, seg=66 (digit 0 = 4)
  - an=1101, seg=4F (digit 1 = 3)
  - an=1011, seg=5B (digit 2 = 2)
  - an=0111, seg=06 (digit 3 = 1)
- Wrap and slot_done: after 16 cycles of scanning -> slot_done pulses exactly once per 16 cycles; the next slot is digit 0 again with an=1110.
- Mid-slot load: during the digit 0 LIT phase, load 16'h000A -> seg changes from 66 to 77 one cycle after the load edge; an is unchanged.
- Hex range: load 16'hFEDC -> digits 0..3 show 39, 5E, 79, 71.
- SEG7_LEADING_ZERO_BLANK_EN: load 16'h0040 -> digits 3 and 2 show seg=00 (an still low in their slots), digit 1 shows 66, digit 0 shows 3F; with the macro undefined, digits 3 and 2 show 3F.
